alu_issue_ctrl: RTL and testbench



---
 rtl/alu_issue_ctrl.sv | 159 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller for the 8-bit combinational ALU: owns an 8x8 register file and flags.
// Optional CMP instruction (op 9) is enabled by defining ALU_ISSUE_CTRL_CMP_EN.
module alu_issue_ctrl #(
  parameter int         EXEC_CYCLES = 1,
  parameter logic [7:0] REG_INIT    = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [7:0]  alu_opcode,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic [7:0]  alu_result,
  input  logic        alu_zero,
  input  logic        alu_carry,
  input  logic        alu_negative,
  output logic [2:0]  flags,
  output logic        done,
  output logic        err,
  input  logic [2:0]  dbg_addr,
  output logic [7:0]  dbg_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] CNT_LOAD = 2'(EXEC_CYCLES - 1);

  state_t      state_r;
  logic [3:0]  op_r;
  logic [2:0]  rd_r;
  logic [7:0]  imm_r;
  logic [1:0]  cnt_r;
  logic [7:0]  regs_r [0:7];
  logic [7:0]  alu_opcode_r;
  logic [7:0]  alu_a_r;
  logic [7:0]  alu_b_r;
  logic [2:0]  flags_r;
  logic        done_r;
  logic        err_r;
  logic        is_alu_s;
  logic        is_ldi_s;
  logic        is_cmp_s;
  logic        legal_s;

  // Opcode presented to the ALU; CMP reuses the SUB datapath.
  function automatic logic [7:0] opcode_map(input logic [3:0] op);
`ifdef ALU_ISSUE_CTRL_CMP_EN
    if (op == 4'd9) begin
      opcode_map = 8'h03;
    end else begin
      opcode_map = {4'b0000, op};
    end
`else
    opcode_map = {4'b0000, op};
`endif
  endfunction

  // Classify the latched opcode for the writeback decision.
  always_comb begin
    is_alu_s = (op_r[3] == 1'b0);
    is_ldi_s = (op_r == 4'd8);
`ifdef ALU_ISSUE_CTRL_CMP_EN
    is_cmp_s = (op_r == 4'd9);
`else
    is_cmp_s = 1'b0;
`endif
    legal_s = is_alu_s | is_ldi_s | is_cmp_s;
  end

  // Issue FSM, register file and flag writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      op_r         <= 4'd0;
      rd_r         <= 3'd0;
      imm_r        <= 8'h00;
      cnt_r        <= 2'd0;
      alu_opcode_r <= 8'h00;
      alu_a_r      <= 8'h00;
      alu_b_r      <= 8'h00;
      flags_r      <= 3'b000;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      regs_r[0]    <= 8'h00;
      for (int i = 1; i < 8; i++) begin
        regs_r[i] <= REG_INIT;
      end
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (instr_valid) begin
            op_r         <= instr[15:12];
            rd_r         <= instr[11:9];
            imm_r        <= instr[7:0];
            alu_opcode_r <= opcode_map(instr[15:12]);
            alu_a_r      <= regs_r[instr[8:6]];
            alu_b_r      <= regs_r[instr[5:3]];
            cnt_r        <= CNT_LOAD;
            state_r      <= EXEC;
          end else begin
            state_r <= IDLE;
          end
        end
        EXEC: begin
          if (cnt_r == 2'd0) begin
            // r0 is hard-wired to zero, so its writes are dropped but flags still update.
            if (is_alu_s) begin
              if (rd_r != 3'd0) begin
                regs_r[rd_r] <= alu_result;
              end else begin
                regs_r[0] <= 8'h00;
              end
              flags_r <= {alu_negative, alu_carry, alu_zero};
            end else if (is_ldi_s) begin
              if (rd_r != 3'd0) begin
                regs_r[rd_r] <= imm_r;
              end else begin
                regs_r[0] <= 8'h00;
              end
            end else if (is_cmp_s) begin
              flags_r <= {alu_negative, alu_carry, alu_zero};
            end else begin
              flags_r <= flags_r;
            end
            done_r  <= 1'b1;
            err_r   <= ~legal_s;
            state_r <= DONE;
          end else begin
            cnt_r <= cnt_r - 2'd1;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign instr_ready = (state_r == IDLE) && !rst;
  assign alu_opcode  = alu_opcode_r;
  assign alu_a       = alu_a_r;
  assign alu_b       = alu_b_r;
  assign flags       = flags_r;
  assign done        = done_r;
  assign err         = err_r;
  assign dbg_data    = regs_r[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: one instance with EXEC_CYCLES=1, one with EXEC_CYCLES=3.
module tb_alu_issue_ctrl;

  logic clk;
  int   checks;
  int   failures;

  // DUT1: EXEC_CYCLES=1, REG_INIT=0
  logic        rst1, valid1, ready1, done1, err1;
  logic [15:0] instr1;
  logic [7:0]  opc1, a1, b1, res1, dbgd1;
  logic        z1, c1, n1;
  logic [2:0]  flags1, dbga1;
  logic [10:0] m1;

  // DUT3: EXEC_CYCLES=3, REG_INIT=A5
  logic        rst3, valid3, ready3, done3, err3;
  logic [15:0] instr3;
  logic [7:0]  opc3, a3, b3, res3, dbgd3;
  logic        z3, c3, n3;
  logic [2:0]  flags3, dbga3;
  logic [10:0] m3;

  // Reference ALU: returns {N, C, Z, result}; SUB carry is the borrow.
  function automatic logic [10:0] alu_model(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] t;
    logic [7:0] r;
    logic       c;
    t = 9'd0;
    case (op)
      8'h00: begin r = a & b; c = 1'b0; end
      8'h01: begin r = a | b; c = 1'b0; end
      8'h02: begin t = {1'b0, a} + {1'b0, b}; r = t[7:0]; c = t[8]; end
      8'h03: begin t = {1'b0, a} - {1'b0, b}; r = t[7:0]; c = t[8]; end
      8'h04: begin r = a ^ b; c = 1'b0; end
      8'h05: begin r = {a[6:0], 1'b0}; c = a[7]; end
      8'h06: begin r = {1'b0, a[7:1]}; c = a[0]; end
      8'h07: begin r = a | b; c = 1'b0; end
      default: begin r = 8'h00; c = 1'b0; end
    endcase
    return {r[7], c, (r == 8'h00), r};
  endfunction

  assign m1   = alu_model(opc1, a1, b1);
  assign res1 = m1[7:0];
  assign z1   = m1[8];
  assign c1   = m1[9];
  assign n1   = m1[10];
  assign m3   = alu_model(opc3, a3, b3);
  assign res3 = m3[7:0];
  assign z3   = m3[8];
  assign c3   = m3[9];
  assign n3   = m3[10];

  alu_issue_ctrl #(.EXEC_CYCLES(1), .REG_INIT(8'h00)) u_dut1 (
    .clk(clk), .rst(rst1), .instr_valid(valid1), .instr_ready(ready1), .instr(instr1),
    .alu_opcode(opc1), .alu_a(a1), .alu_b(b1), .alu_result(res1), .alu_zero(z1),
    .alu_carry(c1), .alu_negative(n1), .flags(flags1), .done(done1), .err(err1),
    .dbg_addr(dbga1), .dbg_data(dbgd1)
  );

  alu_issue_ctrl #(.EXEC_CYCLES(3), .REG_INIT(8'hA5)) u_dut3 (
    .clk(clk), .rst(rst3), .instr_valid(valid3), .instr_ready(ready3), .instr(instr3),
    .alu_opcode(opc3), .alu_a(a3), .alu_b(b3), .alu_result(res3), .alu_zero(z3),
    .alu_carry(c3), .alu_negative(n3), .flags(flags3), .done(done3), .err(err3),
    .dbg_addr(dbga3), .dbg_data(dbgd3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one instruction to DUT1 from IDLE and follow it back to IDLE.
  task automatic run1(input logic [15:0] iw, input logic exp_err,
                      output logic [7:0] x_opc, output logic [7:0] x_a,
                      output logic [7:0] x_b, output logic [7:0] x_dbg);
    int n;
    valid1 = 1'b1;
    instr1 = iw;
    tick();
    valid1 = 1'b0;
    chk("ready_low_exec", 16'(ready1), 16'h0000);
    x_opc = opc1;
    x_a   = a1;
    x_b   = b1;
    x_dbg = dbgd1;
    n = 0;
    while (!done1 && n < 8) begin
      tick();
      n++;
    end
    chk("done_seen", 16'(done1), 16'h0001);
    chk("done_latency", 16'(n), 16'h0001);
    chk("err", 16'(err1), 16'(exp_err));
    chk("ready_low_done", 16'(ready1), 16'h0000);
    tick();
    chk("done_once", 16'(done1), 16'h0000);
    chk("ready_idle", 16'(ready1), 16'h0001);
  endtask

  initial begin
    logic [7:0] xo, xa, xb, xd;
    checks   = 0;
    failures = 0;
    rst1 = 1'b1; valid1 = 1'b0; instr1 = 16'h0000; dbga1 = 3'd0;
    rst3 = 1'b1; valid3 = 1'b0; instr3 = 16'h0000; dbga3 = 3'd0;
    tick();
    tick();

    // Reset state
    chk("rst_ready1", 16'(ready1), 16'h0000);
    chk("rst_opc1", 16'(opc1), 16'h0000);
    chk("rst_a1", 16'(a1), 16'h0000);
    chk("rst_flags1", 16'(flags1), 16'h0000);
    chk("rst_done1", 16'(done1), 16'h0000);
    chk("rst_err1", 16'(err1), 16'h0000);
    dbga3 = 3'd5;
    #1;
    chk("rst_reginit3", 16'(dbgd3), 16'h00A5);
    dbga3 = 3'd0;
    #1;
    chk("rst_r0_3", 16'(dbgd3), 16'h0000);
    rst1 = 1'b0;
    rst3 = 1'b0;
    #1;
    chk("ready_after_rst1", 16'(ready1), 16'h0001);

    // LDI r1,0x0F ; LDI r2,0xF1 ; ADD r3,r1,r2
    run1(16'h820F, 1'b0, xo, xa, xb, xd);
    dbga1 = 3'd1;
    #1;
    chk("ldi_r1", 16'(dbgd1), 16'h000F);
    run1(16'h84F1, 1'b0, xo, xa, xb, xd);
    dbga1 = 3'd2;
    #1;
    chk("ldi_r2", 16'(dbgd1), 16'h00F1);
    run1(16'h2650, 1'b0, xo, xa, xb, xd);
    chk("add_opc", 16'(xo), 16'h0002);
    chk("add_a", 16'(xa), 16'h000F);
    chk("add_b", 16'(xb), 16'h00F1);
    dbga1 = 3'd3;
    #1;
    chk("add_r3", 16'(dbgd1), 16'h0000);
    chk("add_flags", 16'(flags1), 16'h0003);

    // SHL r4,r2 ; r4 still reads its old value during the write cycle
    dbga1 = 3'd4;
    run1(16'h5880, 1'b0, xo, xa, xb, xd);
    chk("shl_prewrite", 16'(xd), 16'h0000);
    chk("shl_r4", 16'(dbgd1), 16'h00E2);
    chk("shl_flags", 16'(flags1), 16'h0006);

    // LDI r0,0x55 : discarded, flags kept
    run1(16'h8055, 1'b0, xo, xa, xb, xd);
    dbga1 = 3'd0;
    #1;
    chk("ldi_r0", 16'(dbgd1), 16'h0000);
    chk("ldi_r0_flags", 16'(flags1), 16'h0006);

    // Illegal op 0xF targeting r1
    run1(16'hF2FF, 1'b1, xo, xa, xb, xd);
    dbga1 = 3'd1;
    #1;
    chk("illegal_r1", 16'(dbgd1), 16'h000F);
    chk("illegal_flags", 16'(flags1), 16'h0006);

    // LDI r1,0x22 ; op 9 CMP r1,r1
    run1(16'h8222, 1'b0, xo, xa, xb, xd);
`ifdef ALU_ISSUE_CTRL_CMP_EN
    run1(16'h9048, 1'b0, xo, xa, xb, xd);
    chk("cmp_opc", 16'(xo), 16'h0003);
    chk("cmp_flags", 16'(flags1), 16'h0001);
`else
    run1(16'h9048, 1'b1, xo, xa, xb, xd);
    chk("op9_flags", 16'(flags1), 16'h0006);
`endif
    #1;
    chk("op9_r1", 16'(dbgd1), 16'h0022);

    // DUT3 back-to-back: ADD r3,r1,r2 then XOR r4,r3,r1 with valid held high
    valid3 = 1'b1;
    instr3 = 16'h2650;
    tick();
    for (int k = 0; k < 10; k++) begin
      chk("b2b_ready", 16'(ready3), (k == 4 || k == 9) ? 16'h0001 : 16'h0000);
      chk("b2b_done", 16'(done3), (k == 3 || k == 8) ? 16'h0001 : 16'h0000);
      chk("b2b_opc", 16'(opc3), (k < 5) ? 16'h0002 : 16'h0004);
      chk("b2b_a", 16'(a3), (k < 5) ? 16'h00A5 : 16'h004A);
      if (k == 0) instr3 = 16'h48C8;
      if (k == 8) valid3 = 1'b0;
      tick();
    end
    dbga3 = 3'd3;
    #1;
    chk("b2b_r3", 16'(dbgd3), 16'h004A);
    dbga3 = 3'd4;
    #1;
    chk("b2b_r4", 16'(dbgd3), 16'h00EF);
    chk("b2b_flags", 16'(flags3), 16'h0004);

    // DUT3 reset one cycle into EXEC of ADD r6,r1,r4
    valid3 = 1'b1;
    instr3 = 16'h2C60;
    tick();
    valid3 = 1'b0;
    tick();
    rst3 = 1'b1;
    tick();
    chk("abort_ready_in_rst", 16'(ready3), 16'h0000);
    chk("abort_done", 16'(done3), 16'h0000);
    chk("abort_flags", 16'(flags3), 16'h0000);
    chk("abort_opc", 16'(opc3), 16'h0000);
    rst3 = 1'b0;
    #1;
    chk("abort_ready_after", 16'(ready3), 16'h0001);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("abort_no_done", 16'(done3), 16'h0000);
    end
    dbga3 = 3'd6;
    #1;
    chk("abort_r6", 16'(dbgd3), 16'h00A5);
    dbga3 = 3'd4;
    #1;
    chk("abort_r4", 16'(dbgd3), 16'h00A5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
